mul_serial_mac_seq: RTL
=======================

Name: mul_serial_mac_seq

Overview:
- Bit-serial signed multiply-accumulate sequencer for the 8-bit binary-serial systolic PE.
- Accepts operand pairs over a valid/ready handshake and holds them stable for WIDTH cycles while it runs an MSB-first shift-add product.
- Folds each product into a running accumulator and emits the accumulator over a valid/ready handshake when the pair is tagged last.
- Sits between the operand skew buffers upstream and the PE output/psum shift chain downstream.

Parameters:
- WIDTH, 8, operand width in bits (signed two's complement).
- DEPTH, 3, bit-counter width; must equal clog2(WIDTH).
- ACC_WIDTH, 24, accumulator/output width; must be >= 2*WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: returns to IDLE and zeroes the accumulator.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  WIDTH  signed multiplier; consumed serially, MSB first.
- in_b  in  WIDTH  signed multiplicand.
- in_last  in  1  pair closes the accumulation group; emit result after it.
- out_valid  out  1  accumulated result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_WIDTH  signed accumulated sum.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, cnt=0, prod=0, acc=0, a_q=b_q=last_q=0, in_ready=1, out_valid=0, out_data=0, busy=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a_q/b_q/last_q, set prod=0, cnt=WIDTH-1, go to MUL.
  - MUL: runs exactly WIDTH cycles. Let bb = a_q[cnt] ? sext(b_q) : 0, on 2*WIDTH bits.
    - When cnt==WIDTH-1 (sign bit): prod <= -bb.
    - Otherwise: prod <= (prod<<1) + bb.
    - cnt decrements each cycle. Leave MUL after the cnt==0 cycle.
    - Final prod equals a_q*b_q exactly as a 2*WIDTH-bit signed value.
  - ACC: acc <= acc + sext(prod), wrapping modulo 2^ACC_WIDTH with no saturation.
    - If last_q, go to OUT. Otherwise go to IDLE.
  - OUT: out_valid=1, out_data=acc held stable.
    - On out_ready, go to IDLE and set acc=0 so the next group starts fresh.
    - out_data keeps its value after the handshake.
- in_ready is high only in IDLE, so there is no operand overlap. Throughput is one pair per WIDTH+2 cycles, plus output stall.
- Latency: input handshake in cycle 0. MUL occupies cycles 1..WIDTH. ACC is cycle WIDTH+1. out_valid rises in cycle WIDTH+2 (cycle 10 for WIDTH=8).
- out_valid must not drop and out_data must not change until out_ready is seen. in_ready stays low throughout OUT.
- Precedence: rst_n > clr > normal operation.
  - clr in any state forces IDLE and acc=0.
  - clr drops out_valid on the next edge; the pending result is discarded.
  - clr takes priority over an in_valid handshake in the same cycle; the operand is not captured.
- Reset asserted mid-MUL or in OUT: every register returns to its reset value immediately; no partial result is emitted.
- Boundary values: a=b=-(2^(WIDTH-1)) gives +2^(2*WIDTH-2) and must not overflow prod.

Decomposition:
- Package mul_serial_pkg holds:
  - state enum typedef: IDLE, MUL, ACC, OUT;
  - WIDTH/DEPTH/ACC_WIDTH default constants.
- One sub-module, mul_serial_step: combinational single shift-add step.
  - Inputs: prod, bit, b, first.
  - Output: next prod.
  - Kept separate so it can be unit-tested against a*b in isolation.
- Everything else (FSM, counter, accumulator, handshakes) lives in the top module.

Test Plan:
- Single pair a=3, b=5, last=1, out_ready=1 -> out_valid in cycle 10, out_data=15, in_ready back high in cycle 11.
- Corners, each with last=1:
  - a=-128, b=-128 -> out_data=16384;
  - a=-1, b=127 -> out_data=-127;
  - a=127, b=-128 -> out_data=-16256.
- Group (2,3,last=0), (4,5,0), (-6,7,1) -> a single out_valid with out_data=-16. acc is 0 afterwards: a following pair (1,1,1) yields 1.
- Backpressure: out_ready low for 5 cycles in OUT -> out_valid and out_data=15 held, in_ready=0; the handshake completes when out_ready rises.
- Abort/reset:
  - clr pulsed in the 4th MUL cycle -> IDLE next cycle, no output, next group starts with acc=0;
  - rst_n low mid-OUT -> out_valid=0 immediately.
- Randomized: 1000 random signed pairs with random last and random out_ready -> every output equals a reference sum wrapped to ACC_WIDTH bits; no handshake rule violated.

Source files
------------

// File: rtl/mul_serial_pkg.sv
// mul_serial_pkg: shared state encoding and default sizes for the bit-serial MAC sequencer
package mul_serial_pkg;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 3;
    localparam int DEF_ACC_WIDTH = 24;
    typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;
endpackage

// File: rtl/mul_serial_step.sv
// mul_serial_step: one MSB-first signed shift-add step; the sign bit contributes with negative weight
module mul_serial_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic               a_bit,
    input  logic [WIDTH-1:0]   b,
    input  logic               first,
    output logic [2*WIDTH-1:0] prod_next
);
    logic [2*WIDTH-1:0] bb;
    always_comb begin
        bb        = a_bit ? {{WIDTH{b[WIDTH-1]}}, b} : '0;
        prod_next = first ? -bb : (prod << 1) + bb;
    end
endmodule

// File: rtl/mul_serial_mac_seq.sv
// mul_serial_mac_seq: bit-serial signed MAC; multiplies pairs over WIDTH cycles, emits the group sum on last
module mul_serial_mac_seq
    import mul_serial_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 busy
);
    state_t               state;
    logic [DEPTH-1:0]     cnt;
    logic [2*WIDTH-1:0]   prod, prod_next;
    logic [ACC_WIDTH-1:0] acc, acc_sum;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 last_q;

    mul_serial_step #(.WIDTH(WIDTH)) u_step (
        .prod      (prod),
        .a_bit     (a_q[cnt]),
        .b         (b_q),
        .first     (cnt == DEPTH'(WIDTH - 1)),
        .prod_next (prod_next)
    );

    always_comb begin
        acc_sum   = acc + ACC_WIDTH'($signed(prod));
        in_ready  = state == IDLE;
        out_valid = state == OUT;
        busy      = state != IDLE;
    end

    // out_data is its own register so it survives the acc clear at the output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            prod     <= '0;
            acc      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            last_q   <= 1'b0;
            out_data <= '0;
        end else if (clr) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q    <= in_a;
                    b_q    <= in_b;
                    last_q <= in_last;
                    prod   <= '0;
                    cnt    <= DEPTH'(WIDTH - 1);
                    state  <= MUL;
                end
                MUL: begin
                    prod  <= prod_next;
                    cnt   <= cnt - DEPTH'(1);
                    state <= cnt == '0 ? ACC : MUL;
                end
                ACC: begin
                    acc   <= acc_sum;
                    state <= last_q ? OUT : IDLE;
                    if (last_q) out_data <= acc_sum;
                end
                OUT: if (out_ready) begin
                    acc   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
